sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 15, consecutive denied GPU-request cycles before GPU is forced a slot.
REQ-002 SHALL have parameter ADDR_W, default 18, SRAM word-address width.
REQ-003 SHALL have parameter DATA_W, default 16, SRAM data width.
REQ-004 SHALL have ports I_CLK in 1 clock; I_RST_N in 1 reset -- asynchronous, active-low.
REQ-005 SHALL have I_VIDEO_ON in 1: 1 = active scan region, 0 = blanking.
REQ-006 SHALL have the video port I_VID_REQ in 1 read request; I_VID_ADDR in ADDR_W; O_VID_ACK out 1; O_VID_RDATA out DATA_W; O_VID_RVALID out 1.
REQ-007 SHALL have the GPU port I_GPU_REQ in 1; I_GPU_WRITE in 1 (1 = write); I_GPU_ADDR in ADDR_W; I_GPU_WDATA in DATA_W; O_GPU_ACK out 1; O_GPU_RDATA out DATA_W; O_GPU_RVALID out 1.
REQ-008 SHALL have the SRAM port O_SRAM_ADDR out ADDR_W; O_SRAM_WDATA out DATA_W; I_SRAM_RDATA in DATA_W; O_SRAM_WE_N out 1; O_SRAM_OE_N out 1; O_SRAM_DQ_OE out 1.

Function
REQ-009 SHALL implement FSM states IDLE, VID_RD, GPU_RD, GPU_WR, TURN; every SRAM access lasts exactly one cycle.
REQ-010 SHALL make a grant decision on each edge where the state is IDLE, VID_RD, GPU_RD or TURN; from GPU_WR, a decision selecting a read SHALL go to TURN first (one idle bus cycle), while a decision selecting a write SHALL go directly to GPU_WR.
REQ-011 SHALL, while I_VIDEO_ON=1, grant video over GPU; while I_VIDEO_ON=0, grant GPU over video.
REQ-012 SHALL count cycles with I_GPU_REQ=1 and no GPU grant, saturating at STARVE_LIMIT; at STARVE_LIMIT, the next decision SHALL grant GPU regardless of video; counter SHALL clear on GPU grant or I_GPU_REQ=0.
REQ-013 SHALL assert the winner's ACK for exactly the access-state cycle, and SHALL register ADDR, WDATA and controls at entry into that state.
REQ-014 SHALL require a requester to hold REQ, ADDR, WRITE and WDATA stable until ACK; REQ held high after ACK is a new back-to-back request.
REQ-015 SHALL, in VID_RD and GPU_RD, drive OE_N=0, WE_N=1 and DQ_OE=0; in GPU_WR, drive WE_N=0, OE_N=1 and DQ_OE=1; otherwise drive WE_N=1, OE_N=1 and DQ_OE=0.
REQ-016 SHALL sample I_SRAM_RDATA at the end of a read state and present it on the owner's RDATA with RVALID high for one cycle, i.e. one cycle after ACK; RDATA SHALL hold until the next RVALID.
REQ-017 SHALL produce no RVALID for writes, and SHALL keep ADDR stable and WE_N high in TURN.
REQ-018 SHALL return to IDLE when no request is pending at a decision.

Reset
REQ-019 SHALL, on I_RST_N=0 at any time including mid-access, immediately force state IDLE, starvation counter 0, ADDR 0, WDATA 0, WE_N 1, OE_N 1, DQ_OE 0, both ACKs 0, both RVALIDs 0 and both RDATAs 0; an in-flight access SHALL be dropped without ACK or RVALID.

Structure
REQ-020 SHALL place the FSM state enumeration and the ADDR_W/DATA_W defaults in shared package sram_arb_pkg.
REQ-021 SHALL implement the saturating starvation counter as sub-module sram_arb_starve_ctr.

Verification
REQ-022 SHALL check: I_VIDEO_ON=1, both requests from cycle 0 with video held high -> VID_ACK on cycles 1-15, GPU_ACK on cycle 16, then video resumes.
REQ-023 SHALL check: I_VIDEO_ON=0, GPU write to 0x00280 with 0xFFFF, then video read of the same address -> WE_N low one cycle, TURN cycle, VID_RVALID with VID_RDATA=0xFFFF.
REQ-024 SHALL check: GPU back-to-back writes to 0x00000-0x00003 with no video request -> four consecutive WE_N-low cycles, no TURN inserted.
REQ-025 SHALL check: GPU read of 0x3FFFF with model data 0x1234 -> GPU_RVALID one cycle after GPU_ACK, GPU_RDATA=0x1234.
REQ-026 SHALL check: I_RST_N asserted during GPU_WR -> WE_N=1, DQ_OE=0 and ACKs 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM arbiter slice.
package sram_arb_pkg;

    localparam int unsigned ADDR_W_DEF       = 18;
    localparam int unsigned DATA_W_DEF       = 16;
    localparam int unsigned STARVE_LIMIT_DEF = 15;

    // Bus owner / access phase; each access state lasts exactly one cycle.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VID_RD = 3'd1,
        GPU_RD = 3'd2,
        GPU_WR = 3'd3,
        TURN   = 3'd4
    } arb_state_e;

    function automatic logic is_read_state(input arb_state_e s);
        return (s == VID_RD) || (s == GPU_RD);
    endfunction

endpackage

// File: rtl/sram_arb_starve_ctr.sv
// Saturating count of cycles the GPU has been requesting without a grant.
module sram_arb_starve_ctr #(
    parameter int unsigned LIMIT = 15
) (
    input  logic I_CLK,
    input  logic I_RST_N,
    input  logic gpu_req,
    input  logic gpu_grant,
    output logic starved
);

    localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    // Clear on grant or idle requester, otherwise count up to LIMIT and hold.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            cnt_q <= '0;
        end else if (!gpu_req || gpu_grant) begin
            cnt_q <= '0;
        end else if (cnt_q != CW'(LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign starved = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/sram_arbiter.sv
// Single-port async SRAM arbiter between a video scan-out reader and a GPU
// read/write port. One-cycle accesses, registered SRAM controls, and a bus
// turnaround cycle whenever a read follows a write.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF
) (
    input  logic              I_CLK,
    input  logic              I_RST_N,
    input  logic              I_VIDEO_ON,
    // video read port
    input  logic              I_VID_REQ,
    input  logic [ADDR_W-1:0] I_VID_ADDR,
    output logic              O_VID_ACK,
    output logic [DATA_W-1:0] O_VID_RDATA,
    output logic              O_VID_RVALID,
    // GPU read/write port
    input  logic              I_GPU_REQ,
    input  logic              I_GPU_WRITE,
    input  logic [ADDR_W-1:0] I_GPU_ADDR,
    input  logic [DATA_W-1:0] I_GPU_WDATA,
    output logic              O_GPU_ACK,
    output logic [DATA_W-1:0] O_GPU_RDATA,
    output logic              O_GPU_RVALID,
    // SRAM port
    output logic [ADDR_W-1:0] O_SRAM_ADDR,
    output logic [DATA_W-1:0] O_SRAM_WDATA,
    input  logic [DATA_W-1:0] I_SRAM_RDATA,
    output logic              O_SRAM_WE_N,
    output logic              O_SRAM_OE_N,
    output logic              O_SRAM_DQ_OE
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       starved;
    logic       gpu_pick;
    logic       vid_pick;
    logic       gpu_grant;

    sram_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .I_CLK     (I_CLK),
        .I_RST_N   (I_RST_N),
        .gpu_req   (I_GPU_REQ),
        .gpu_grant (gpu_grant),
        .starved   (starved)
    );

    // Grant decision every cycle. A read chosen straight after a write parks
    // in TURN without being granted; TURN then re-arbitrates, so the starvation
    // counter only clears on a real GPU access.
    always_comb begin
        state_d   = IDLE;
        gpu_grant = 1'b0;
        gpu_pick  = I_GPU_REQ && (starved || !I_VID_REQ || !I_VIDEO_ON);
        vid_pick  = I_VID_REQ && !gpu_pick;
        if (gpu_pick) begin
            if (I_GPU_WRITE) begin
                state_d   = GPU_WR;
                gpu_grant = 1'b1;
            end else if (state_q == GPU_WR) begin
                state_d = TURN;
            end else begin
                state_d   = GPU_RD;
                gpu_grant = 1'b1;
            end
        end else if (vid_pick) begin
            state_d = (state_q == GPU_WR) ? TURN : VID_RD;
        end
    end

    // State register.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // SRAM address/data/strobes and ACKs registered on entry to the next state.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            O_SRAM_ADDR  <= '0;
            O_SRAM_WDATA <= '0;
            O_SRAM_WE_N  <= 1'b1;
            O_SRAM_OE_N  <= 1'b1;
            O_SRAM_DQ_OE <= 1'b0;
            O_VID_ACK    <= 1'b0;
            O_GPU_ACK    <= 1'b0;
        end else begin
            O_SRAM_WE_N  <= (state_d != GPU_WR);
            O_SRAM_OE_N  <= !is_read_state(state_d);
            O_SRAM_DQ_OE <= (state_d == GPU_WR);
            O_VID_ACK    <= (state_d == VID_RD);
            O_GPU_ACK    <= (state_d == GPU_RD) || (state_d == GPU_WR);
            case (state_d)
                VID_RD: O_SRAM_ADDR <= I_VID_ADDR;
                GPU_RD: O_SRAM_ADDR <= I_GPU_ADDR;
                GPU_WR: begin
                    O_SRAM_ADDR  <= I_GPU_ADDR;
                    O_SRAM_WDATA <= I_GPU_WDATA;
                end
                default: ;
            endcase
        end
    end

    // Capture read data at the end of a read cycle; RDATA holds between RVALIDs.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            O_VID_RDATA  <= '0;
            O_VID_RVALID <= 1'b0;
            O_GPU_RDATA  <= '0;
            O_GPU_RVALID <= 1'b0;
        end else begin
            O_VID_RVALID <= (state_q == VID_RD);
            O_GPU_RVALID <= (state_q == GPU_RD);
            if (state_q == VID_RD) begin
                O_VID_RDATA <= I_SRAM_RDATA;
            end
            if (state_q == GPU_RD) begin
                O_GPU_RDATA <= I_SRAM_RDATA;
            end
        end
    end

endmodule
